// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: XLEN, next-PC select
// encodings and the fetch FSM state type.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JAL  = 2'b11;
  localparam logic [1:0] PC_JALR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational redirect target and alignment check for fetch_unit.
// Behaviour depends on FETCH_MISALIGN_TRAP_EN (flag bit1 instead of forcing it to 0).
module next_pc_gen
  import fetch_unit_pkg::*;
(
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic            take,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  logic [XLEN-1:0] rel_sum;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] raw;

  always_comb begin
    rel_sum  = ex_pc + imm;
    jalr_sum = rs1 + imm;
    take     = (pc_sel != PC_SEQ);
    raw      = (pc_sel == PC_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : rel_sum;
`ifdef FETCH_MISALIGN_TRAP_EN
    target   = raw;
    misalign = raw[1];
`else
    target   = {raw[XLEN-1:2], 2'b00};
    misalign = 1'b0;
`endif
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: IDLE/REQ/WAIT/HOLD FSM with
// branch/jump redirect and kill of in-flight responses. Option: FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_i,
  input  logic [1:0]      pc_sel_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  output logic            misalign_o
);

  fetch_state_t    state, state_nx;
  logic [XLEN-1:0] pc, pc_nx;
  logic            kill, kill_nx;
  logic            mis, mis_nx;
  logic            valid, valid_nx;
  logic [XLEN-1:0] instr, instr_nx;
  logic [XLEN-1:0] instr_pc, instr_pc_nx;

  logic            take;
  logic [XLEN-1:0] target;
  logic            tgt_mis;
  logic            redirect;

  next_pc_gen u_next_pc (
    .pc_sel   (pc_sel_i),
    .ex_pc    (ex_pc_i),
    .imm      (imm_i),
    .rs1      (rs1_i),
    .take     (take),
    .target   (target),
    .misalign (tgt_mis)
  );

  assign redirect = redirect_i && take;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      kill     <= 1'b0;
      mis      <= 1'b0;
      valid    <= 1'b0;
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      kill     <= kill_nx;
      mis      <= mis_nx;
      valid    <= valid_nx;
      instr    <= instr_nx;
      instr_pc <= instr_pc_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    kill_nx     = kill;
    mis_nx      = mis;
    valid_nx    = valid;
    instr_nx    = instr;
    instr_pc_nx = instr_pc;
    unique case (state)
      S_IDLE: state_nx = S_REQ;
      S_REQ: begin
        if (redirect) begin
          pc_nx    = target;
          mis_nx   = tgt_mis;
          valid_nx = 1'b0;
          // A grant taken together with a redirect leaves a stale response in flight.
          if (imem_gnt_i) begin
            state_nx = S_WAIT;
            kill_nx  = 1'b1;
          end else begin
            state_nx = tgt_mis ? S_HOLD : S_REQ;
          end
        end else if (imem_gnt_i) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_nx  = target;
          mis_nx = tgt_mis;
          if (imem_rvalid_i) begin
            kill_nx  = 1'b0;
            state_nx = tgt_mis ? S_HOLD : S_REQ;
          end else begin
            kill_nx = 1'b1;
          end
        end else if (imem_rvalid_i) begin
          if (kill) begin
            kill_nx  = 1'b0;
            state_nx = mis ? S_HOLD : S_REQ;
          end else begin
            instr_nx    = imem_rdata_i;
            instr_pc_nx = pc;
            valid_nx    = 1'b1;
            pc_nx       = pc + 32'd4;
            state_nx    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_nx    = target;
          mis_nx   = tgt_mis;
          valid_nx = 1'b0;
          state_nx = tgt_mis ? S_HOLD : S_REQ;
        end else if (!mis && instr_ready_i) begin
          valid_nx = 1'b0;
          state_nx = S_REQ;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign imem_req_o    = (state == S_REQ);
  assign imem_addr_o   = pc;
  assign instr_valid_o = valid;
  assign instr_o       = instr;
  assign instr_pc_o    = instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_o    = mis;
`else
  assign misalign_o    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: redirect target table plus
// hand-written fetch, kill, hold, wrap and reset sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic [31:0] ex_pc = '0;
  logic [31:0] imm = '0;
  logic [31:0] rs1 = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        ready = 1'b0;
  logic        misalign;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] ex_pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] tgt;
    logic        mis;
  } vec_t;

  vec_t vecs[9];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .redirect_i    (redirect),
    .pc_sel_i      (pc_sel),
    .ex_pc_i       (ex_pc),
    .imm_i         (imm),
    .rs1_i         (rs1),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .instr_valid_o (instr_valid),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_ready_i (ready),
    .misalign_o    (misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_redirect(input logic [1:0] s, input logic [31:0] e,
                              input logic [31:0] i, input logic [31:0] r);
    redirect = 1'b1;
    pc_sel   = s;
    ex_pc    = e;
    imm      = i;
    rs1      = r;
  endtask

  task automatic clr_redirect();
    redirect = 1'b0;
    pc_sel   = 2'b00;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", {31'b0, imem_req}, 32'd1);
  endtask

  task automatic serve(input logic [31:0] data, input logic [31:0] addr, input int hold);
    wait_req();
    chk("req_addr", imem_addr, addr);
    gnt = 1'b1;
    step();
    gnt    = 1'b0;
    rvalid = 1'b1;
    rdata  = data;
    step();
    rvalid = 1'b0;
    rdata  = 32'hBAD0_BAD0;
    chk("instr_valid", {31'b0, instr_valid}, 32'd1);
    chk("instr", instr, data);
    chk("instr_pc", instr_pc, addr);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_instr", instr, data);
      chk("hold_pc", instr_pc, addr);
      chk("hold_valid", {31'b0, instr_valid}, 32'd1);
      chk("hold_no_req", {31'b0, imem_req}, 32'd0);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("valid_cleared", {31'b0, instr_valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{2'b01, 32'h0000_0100, 32'hFFFF_FFF0, 32'h0,         32'h0000_00F0, 1'b0};
    vecs[1] = '{2'b10, 32'h0,         32'h0000_0004, 32'h0000_2001, 32'h0000_2004, 1'b0};
    vecs[2] = '{2'b11, 32'h0000_1000, 32'h0000_0020, 32'h0,         32'h0000_1020, 1'b0};
    vecs[3] = '{2'b00, 32'h0000_5000, 32'h0000_0010, 32'h0,         32'h0000_1020, 1'b0};
    vecs[4] = '{2'b10, 32'h0,         32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[5] = '{2'b11, 32'h0000_0100, 32'h0000_0002, 32'h0,         32'h0000_0102, 1'b1};
    vecs[6] = '{2'b10, 32'h0,         32'h0000_0000, 32'h0000_0007, 32'h0000_0006, 1'b1};
    vecs[7] = '{2'b01, 32'h8000_0000, 32'h7FFF_FFFC, 32'h0,         32'hFFFF_FFFC, 1'b0};
    vecs[8] = '{2'b10, 32'h0,         32'hFFFF_FFF8, 32'h0000_0010, 32'h0000_0008, 1'b0};

    // Reset values
    step();
    step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);
    rst = 1'b0;
    chk("idle_no_req", {31'b0, imem_req}, 32'd0);

    // Sequential fetch, last one stalled by decode
    serve(32'h0000_0011, 32'h0, 0);
    serve(32'h0000_0022, 32'h4, 0);
    serve(32'h0000_0033, 32'h8, 5);

    // Redirect while waiting: response killed
    wait_req();
    chk("wait_addr", imem_addr, 32'hC);
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    set_redirect(2'b01, 32'h0000_0100, 32'hFFFF_FFF0, 32'h0);
    step();
    clr_redirect();
    chk("kill_wait_no_req", {31'b0, imem_req}, 32'd0);
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    step();
    rvalid = 1'b0;
    chk("kill_dropped", {31'b0, instr_valid}, 32'd0);
    chk("kill_req", {31'b0, imem_req}, 32'd1);
    chk("kill_addr", imem_addr, 32'h0000_00F0);
    serve(32'h0000_0044, 32'h0000_00F0, 0);

    // Redirect with response in the same cycle
    wait_req();
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    set_redirect(2'b11, 32'h0000_0200, 32'h0000_0040, 32'h0);
    rvalid = 1'b1;
    rdata  = 32'hDEAD_0001;
    step();
    clr_redirect();
    rvalid = 1'b0;
    chk("samecyc_dropped", {31'b0, instr_valid}, 32'd0);
    chk("samecyc_req", {31'b0, imem_req}, 32'd1);
    chk("samecyc_addr", imem_addr, 32'h0000_0240);

    // Grant coinciding with redirect in REQ
    gnt = 1'b1;
    set_redirect(2'b10, 32'h0, 32'h0000_0004, 32'h0000_2001);
    step();
    gnt = 1'b0;
    clr_redirect();
    chk("gntredir_wait", {31'b0, imem_req}, 32'd0);
    rvalid = 1'b1;
    rdata  = 32'hDEAD_0002;
    step();
    rvalid = 1'b0;
    chk("gntredir_dropped", {31'b0, instr_valid}, 32'd0);
    serve(32'h0000_0055, 32'h0000_2004, 0);

    // Redirect while holding a valid instruction
    wait_req();
    gnt = 1'b1;
    step();
    gnt    = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'h0000_0066;
    step();
    rvalid = 1'b0;
    chk("hold_pc_2008", instr_pc, 32'h0000_2008);
    set_redirect(2'b01, 32'h0000_0300, 32'h0000_0008, 32'h0);
    step();
    clr_redirect();
    chk("holdredir_valid", {31'b0, instr_valid}, 32'd0);
    chk("holdredir_addr", imem_addr, 32'h0000_0308);

    // Redirect target table, applied from REQ with no grant
    for (int v = 0; v < 9; v++) begin
      set_redirect(vecs[v].sel, vecs[v].ex_pc, vecs[v].imm, vecs[v].rs1);
      step();
      clr_redirect();
`ifdef FETCH_MISALIGN_TRAP_EN
      if (vecs[v].mis) begin
        chk("vec_mis_flag", {31'b0, misalign}, 32'd1);
        chk("vec_mis_noreq", {31'b0, imem_req}, 32'd0);
        ready = 1'b1;
        step();
        step();
        ready = 1'b0;
        chk("vec_mis_park", {31'b0, imem_req}, 32'd0);
        chk("vec_mis_novalid", {31'b0, instr_valid}, 32'd0);
      end else begin
        chk("vec_addr", imem_addr, vecs[v].tgt);
        chk("vec_req", {31'b0, imem_req}, 32'd1);
        chk("vec_nomis", {31'b0, misalign}, 32'd0);
      end
`else
      chk("vec_addr", imem_addr, {vecs[v].tgt[31:2], 2'b00});
      chk("vec_req", {31'b0, imem_req}, 32'd1);
      chk("vec_nomis", {31'b0, misalign}, 32'd0);
`endif
    end

    // PC wrap
    set_redirect(2'b11, 32'hFFFF_FFF0, 32'h0000_000C, 32'h0);
    step();
    clr_redirect();
    serve(32'h0000_0077, 32'hFFFF_FFFC, 0);
    wait_req();
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset mid-transaction, late response ignored
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    rst = 1'b1;
    step();
    chk("midrst_req", {31'b0, imem_req}, 32'd0);
    rst    = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'hDEAD_0003;
    step();
    step();
    rvalid = 1'b0;
    chk("midrst_late_ignored", {31'b0, instr_valid}, 32'd0);
    serve(32'h0000_0088, 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  reset, asynchronous and active-high.
REQ-004 redirect_i  in  1  qualifies pc_sel_i/ex_pc_i/imm_i/rs1_i from the branch resolution stage for one cycle.
REQ-005 pc_sel_i  in  2  next-PC select: 00 sequential, 01 conditional branch taken, 11 JAL, 10 JALR.
REQ-006 ex_pc_i  in  32  PC of the resolving control-transfer instruction.
REQ-007 imm_i  in  32  sign-extended branch/jump offset.
REQ-008 rs1_i  in  32  JALR base register value.
REQ-009 imem_req_o  out  1  instruction memory request.
REQ-010 imem_addr_o  out  32  request address.
REQ-011 imem_gnt_i  in  1  request accepted this cycle.
REQ-012 imem_rvalid_i  in  1  response data valid.
REQ-013 imem_rdata_i  in  32  response instruction word.
REQ-014 instr_valid_o  out  1  fetched instruction valid to decode.
REQ-015 instr_o  out  32  fetched instruction.
REQ-016 instr_pc_o  out  32  PC of instr_o.
REQ-017 instr_ready_i  in  1  decode accepts instr_o.
REQ-018 misalign_o  out  1  redirect target misaligned (sticky until next redirect).

Function
REQ-019 The unit SHALL run a 4-state FSM: IDLE, REQ, WAIT, HOLD.
REQ-020 IDLE: entered only from reset; one cycle later go to REQ with pc = RESET_PC.
REQ-021 REQ: imem_req_o=1, imem_addr_o=pc; on imem_gnt_i go to WAIT, else stay with address held stable.
REQ-022 WAIT: on imem_rvalid_i latch imem_rdata_i/pc into the output register, set instr_valid_o, pc <= pc+4, go to HOLD.
REQ-023 HOLD: on instr_ready_i clear instr_valid_o and go to REQ in the same cycle, issuing the next request (fetch-to-fetch throughput 1 instruction per 3 cycles minimum with single-cycle memory).
REQ-024 instr_o/instr_pc_o SHALL stay stable while instr_valid_o=1 and instr_ready_i=0.
REQ-025 Redirect target: 01 and 11 -> ex_pc_i+imm_i; 10 -> (rs1_i+imm_i) with bit0 cleared; 00 with redirect_i -> no change; all sums modulo 2^32.
REQ-026 Redirect in REQ or HOLD: pc <= target, instr_valid_o cleared, next state REQ; a grant coinciding with the redirect is treated as in WAIT (REQ-027).
REQ-027 Redirect in WAIT: pc <= target, set kill flag; the pending response, including one arriving the same cycle, SHALL be discarded, then REQ.
REQ-028 At most one outstanding imem request at any time.
REQ-029 pc+4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000.

Reset
REQ-030 On rst_i: state IDLE, pc=RESET_PC, kill=0, imem_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, misalign_o=0.
REQ-031 Reset asserted mid-transaction SHALL abandon it; a late imem_rvalid_i after reset SHALL be ignored.

Configuration
REQ-032 Macro FETCH_MISALIGN_TRAP_EN defined: target with bit1 set sets misalign_o, FSM parks in HOLD with instr_valid_o=0 until the next redirect.
REQ-033 Macro undefined: target bits[1:0] forced to 0, misalign_o tied 0.

Structure
REQ-034 Shared package holds the pc_sel encodings (PC_SEQ, PC_BR, PC_JAL, PC_JALR), FSM state typedef, XLEN=32.
REQ-035 One sub-module, next_pc_gen (combinational target/alignment computation), SHALL be instantiated.

Verification
REQ-036 Reset, gnt/rvalid each 1 cycle after req -> addresses 0x0, 0x4, 0x8; instr_pc_o matches.
REQ-037 redirect_i=1, pc_sel_i=01, ex_pc_i=0x100, imm_i=0xFFFF_FFF0 in WAIT -> response dropped, next imem_addr_o=0xF0.
REQ-038 pc_sel_i=10, rs1_i=0x2001, imm_i=0x4 -> imem_addr_o=0x2004 (bit0 cleared).
REQ-039 instr_ready_i low 5 cycles -> instr_o/instr_pc_o unchanged, no new imem_req_o.
REQ-040 With FETCH_MISALIGN_TRAP_EN, JAL target 0x102 -> misalign_o=1, no request until next redirect.
REQ-041 pc=0xFFFF_FFFC fetched -> next imem_addr_o=0x0.
